// File: rtl/frame_draw_scheduler.sv
// Per-frame draw sequencer: walks the mode/enable-filtered item list, raising one
// draw line at a time, with a plot_done watchdog and frame-overrun accounting.
module frame_draw_scheduler #(
  parameter int TIMEOUT_CYCLES = 131072,
  parameter int GAP_CYCLES     = 2,
  parameter int OVR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [1:0]       mode,
  input  logic [7:0]       en_mask,
  input  logic             plot_done,
  input  logic             err_clear,
  output logic [7:0]       draw_sel,
  output logic             busy,
  output logic             frame_done,
  output logic             err_timeout,
  output logic             overrun,
  output logic [OVR_W-1:0] overrun_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAW, S_GAP, S_END} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [3:0]       idx_q, idx_d;
  logic [2:0]       cur_q, cur_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [3:0]       gap_q, gap_d;
  logic             err_timeout_q, err_timeout_d;
  logic             overrun_q, overrun_d;
  logic [OVR_W-1:0] overrun_count_q, overrun_count_d;

  logic             found;
  logic [2:0]       found_idx;
  logic             busy_st, tick_accept, timeout_evt, overrun_evt;

  function automatic logic [7:0] mode_mask(input logic [1:0] m);
    case (m)
      2'd0:    return 8'h01;
      2'd1:    return 8'h02;
      2'd2:    return 8'hFC;
      default: return 8'h00;
    endcase
  endfunction

  // Lowest latched item at or above the resume index; descending loop keeps the lowest.
  always_comb begin
    found     = 1'b0;
    found_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) >= idx_q)) begin
        found     = 1'b1;
        found_idx = 3'(i);
      end
    end
  end

  assign busy_st     = (state_q == S_SCAN) || (state_q == S_DRAW) || (state_q == S_GAP);
  assign tick_accept = frame_tick && ((state_q == S_IDLE) || (state_q == S_END));
  assign overrun_evt = frame_tick && busy_st;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    timeout_evt = 1'b0;

    case (state_q)
      S_IDLE, S_END: begin
        state_d = S_IDLE;
        if (tick_accept) begin
          mask_d  = mode_mask(mode) & en_mask;
          idx_d   = 4'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (found) begin
          cur_d   = found_idx;
          wd_d    = '0;
          state_d = S_DRAW;
        end else begin
          state_d = S_END;
        end
      end
      S_DRAW: begin
        if (plot_done) begin
          gap_d   = 4'd0;
          state_d = S_GAP;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_evt = 1'b1;
          gap_d       = 4'd0;
          state_d     = S_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) begin
          idx_d   = 4'(cur_q) + 4'd1;
          state_d = S_SCAN;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky status: a new event in the same cycle beats err_clear.
  always_comb begin
    err_timeout_d   = err_timeout_q;
    overrun_d       = overrun_q;
    overrun_count_d = overrun_count_q;
    if (timeout_evt)    err_timeout_d = 1'b1;
    else if (err_clear) err_timeout_d = 1'b0;
    if (overrun_evt) begin
      overrun_d = 1'b1;
      if (overrun_count_q != '1) overrun_count_d = overrun_count_q + 1'b1;
    end else if (err_clear) begin
      overrun_d       = 1'b0;
      overrun_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      mask_q          <= '0;
      idx_q           <= '0;
      cur_q           <= '0;
      wd_q            <= '0;
      gap_q           <= '0;
      err_timeout_q   <= 1'b0;
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      idx_q           <= idx_d;
      cur_q           <= cur_d;
      wd_q            <= wd_d;
      gap_q           <= gap_d;
      err_timeout_q   <= err_timeout_d;
      overrun_q       <= overrun_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign draw_sel      = (state_q == S_DRAW) ? (8'h01 << cur_q) : 8'h00;
  assign busy          = busy_st;
  assign frame_done    = (state_q == S_END);
  assign err_timeout   = err_timeout_q;
  assign overrun       = overrun_q;
  assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_frame_draw_scheduler;
  localparam int TO  = 16;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0, plot_done = 1'b0, err_clear = 1'b0;
  logic [1:0] mode = 2'd2;
  logic [7:0] en_mask = 8'hFF;
  logic [7:0] draw_sel, overrun_count;
  logic       busy, frame_done, err_timeout, overrun;

  always #5 clk = ~clk;

  frame_draw_scheduler #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .OVR_W(8)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .mode(mode), .en_mask(en_mask),
    .plot_done(plot_done), .err_clear(err_clear), .draw_sel(draw_sel), .busy(busy),
    .frame_done(frame_done), .err_timeout(err_timeout), .overrun(overrun),
    .overrun_count(overrun_count));

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Model: phase 0 idle, 1 scan, 2 draw, 3 gap, 4 frame end; items holds the rest of the frame.
  logic [7:0] MODE_MASK [4] = '{8'h01, 8'h02, 8'hFC, 8'h00};
  int  ph = 0, cur = 0, dcnt = 0, gcnt = 0, m_cnt = 0;
  int  items[$];
  bit  m_to = 0, m_ov = 0;

  int         seen[$];
  logic [7:0] prev_sel = 8'h00;
  int         sel_age = 0, fd_count = 0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_frame();
    logic [7:0] m;
    m = MODE_MASK[mode] & en_mask;
    items.delete();
    for (int i = 0; i < 8; i++) if (m[i]) items.push_back(i);
    ph = 1;
  endtask

  task automatic model_step();
    bit was_busy;
    if (reset) begin
      ph = 0; cur = 0; dcnt = 0; gcnt = 0; m_cnt = 0; m_to = 0; m_ov = 0;
      items.delete();
      return;
    end
    was_busy = (ph >= 1 && ph <= 3);
    if (frame_tick && was_busy) begin
      m_ov = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (err_clear) begin
      m_ov = 0; m_cnt = 0;
    end
    if (ph == 2 && !plot_done && dcnt == TO - 1) m_to = 1;
    else if (err_clear) m_to = 0;
    case (ph)
      0: if (frame_tick) load_frame();
      1: if (items.size() == 0) ph = 4;
         else begin cur = items.pop_front(); dcnt = 0; ph = 2; end
      2: if (plot_done || dcnt == TO - 1) begin gcnt = 0; ph = 3; end
         else dcnt++;
      3: if (gcnt == GAP - 1) ph = 1; else gcnt++;
      default: if (frame_tick) load_frame(); else ph = 0;
    endcase
  endtask

  // One clock: advance the model on the edge, then compare every output 1 time unit later.
  task automatic step();
    logic [7:0] exp_sel;
    @(posedge clk);
    model_step();
    #1;
    exp_sel = (ph == 2) ? (8'h01 << cur) : 8'h00;
    check("draw_sel", draw_sel, exp_sel);
    check("busy", busy, (ph >= 1 && ph <= 3));
    check("frame_done", frame_done, ph == 4);
    check("err_timeout", err_timeout, m_to);
    check("overrun", overrun, m_ov);
    check("overrun_count", overrun_count, m_cnt);
    check("onehot", ($countones(draw_sel) <= 1), 1);
    if (draw_sel != 0 && prev_sel == 0) seen.push_back(draw_sel);
    prev_sel = draw_sel;
    sel_age  = (draw_sel != 0) ? sel_age + 1 : 0;
    if (frame_done) fd_count++;
    cyc++;
    frame_tick = 1'b0;
    err_clear  = 1'b0;
  endtask

  task automatic auto_step(int d);
    plot_done = (d >= 0) && (sel_age == d);
    step();
    plot_done = 1'b0;
  endtask

  task automatic run_frame(int d, int budget, string name);
    int start_fd, n;
    start_fd = fd_count;
    n = 0;
    while (fd_count == start_fd && n < budget) begin
      auto_step(d);
      n++;
    end
    check({name, "_frame_done"}, fd_count - start_fd, 1);
  endtask

  task automatic check_seq(string name, int e[$]);
    check({name, "_len"}, seen.size(), e.size());
    for (int i = 0; i < e.size() && i < seen.size(); i++) check(name, seen[i], e[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int e[$];
    // Reset
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    check("rst_draw_sel", draw_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_count", overrun_count, 0);

    // PLAY, all enabled, plot_done 10 cycles into each draw
    mode = 2'd2; en_mask = 8'hFF; seen.delete();
    frame_tick = 1'b1; step();
    run_frame(10, 400, "play");
    e = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80}; check_seq("play_seq", e);
    step(); check("play_idle_busy", busy, 0);

    // START and OVER screens
    mode = 2'd0; seen.delete(); frame_tick = 1'b1; step(); run_frame(3, 100, "start");
    e = '{8'h01}; check_seq("start_seq", e);
    mode = 2'd1; seen.delete(); frame_tick = 1'b1; step(); run_frame(3, 100, "over");
    e = '{8'h02}; check_seq("over_seq", e);

    // Enable filter, mode change mid-frame ignored
    mode = 2'd2; en_mask = 8'hA4; seen.delete(); frame_tick = 1'b1; step();
    mode = 2'd0; en_mask = 8'h01;
    run_frame(4, 200, "a4");
    e = '{8'h04, 8'h20, 8'h80}; check_seq("a4_seq", e);

    // BLANK: frame_done two cycles after the tick edge
    step(); mode = 2'd3; en_mask = 8'hFF; seen.delete();
    frame_tick = 1'b1; step();
    check("blank_n1_fd", frame_done, 0);
    check("blank_n1_busy", busy, 1);
    step();
    check("blank_n2_fd", frame_done, 1);
    check("blank_sel_none", seen.size(), 0);
    step();

    // Watchdog: 16 DRAW cycles without plot_done, then move to the next item
    mode = 2'd2; en_mask = 8'h0C; seen.delete(); frame_tick = 1'b1; step();
    step();
    check("to_first_draw", draw_sel, 8'h04);
    for (int i = 0; i < 15; i++) step();
    check("to_cycle16_sel", draw_sel, 8'h04);
    check("to_cycle16_err", err_timeout, 0);
    step();
    check("to_err_set", err_timeout, 1);
    check("to_sel_low", draw_sel, 0);
    run_frame(3, 100, "to");
    e = '{8'h04, 8'h08}; check_seq("to_seq", e);
    err_clear = 1'b1; step();
    check("to_err_cleared", err_timeout, 0);

    // Overruns, tick in FRAME_END, reset during DRAW
    mode = 2'd2; en_mask = 8'hFF; frame_tick = 1'b1; step();
    for (int k = 0; k < 3; k++) begin
      auto_step(2); auto_step(2); frame_tick = 1'b1; auto_step(2);
    end
    check("ovr_flag", overrun, 1);
    check("ovr_count3", overrun_count, 3);
    for (int n = 0; n < 300 && !frame_done; n++) auto_step(2);
    check("ovr_reached_end", frame_done, 1);
    frame_tick = 1'b1; auto_step(2);
    check("end_tick_busy", busy, 1);
    check("end_tick_fd", frame_done, 0);
    check("end_tick_count", overrun_count, 3);
    auto_step(-1);
    check("end_tick_draw", draw_sel, 8'h04);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_draw_low", draw_sel, 0);
    check("rst_no_fd", frame_done, 0);
    step();
    check("rst_after_fd", frame_done, 0);

    // Saturating overrun counter, set beats clear
    for (int n = 0; n < 400; n++) begin frame_tick = 1'b1; step(); end
    check("sat_count", overrun_count, 255);
    while (!busy && cyc < 20000) step();
    frame_tick = 1'b1; err_clear = 1'b1; step();
    check("set_wins_flag", overrun, 1);
    check("set_wins_count", overrun_count, 255);
    while (!busy && cyc < 20000) step();
    err_clear = 1'b1; step();
    check("clear_count", overrun_count, 0);
    check("clear_flag", overrun, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      frame_tick = ($urandom_range(11) == 0);
      plot_done  = ($urandom_range(5) == 0);
      err_clear  = ($urandom_range(39) == 0);
      reset      = ($urandom_range(699) == 0);
      if ($urandom_range(49) == 0) mode = 2'($urandom);
      if ($urandom_range(49) == 0) en_mask = 8'($urandom);
      step();
    end
    reset = 1'b0; plot_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Per-frame sequencer that owns the datapath draw-select lines.
- On each frame tick it walks a fixed priority list of sprites/screens, filtered by game mode and an enable mask, and raises one draw line at a time. It waits for plot_done, inserts an idle gap, then moves on.
- Sits between game logic (mode, enables, frame tick) and the sprite datapath.
- Also supervises plot_done with a watchdog and counts frame overruns.

Parameters:
- TIMEOUT_CYCLES, 131072: max cycles in DRAW without plot_done before abort (must exceed 320*240).
- GAP_CYCLES, 2: idle cycles with all draw lines low after each item (legal range 1..15).
- OVR_W, 8: width of the overrun counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse requesting a frame redraw.
- mode  in  2  0=START, 1=OVER, 2=PLAY, 3=BLANK.
- en_mask  in  8  per-item enable, bit i = item i.
- plot_done  in  1  from datapath; item finished.
- err_clear  in  1  clears sticky flags and overrun_count.
- draw_sel  out  8  one-hot draw lines. Bit map: 0 scrn_start, 1 scrn_game_over, 2 scrn_game_bg, 3 score, 4 lives, 5 river_obj_1, 6 river_obj_2, 7 frog.
- busy  out  1  high from SCAN through GAP.
- frame_done  out  1  one-cycle pulse at end of frame.
- err_timeout  out  1  sticky; a watchdog abort occurred.
- overrun  out  1  sticky; a tick arrived while busy.
- overrun_count  out  OVR_W  saturating count of dropped ticks.

Behaviour:
- Reset: state IDLE, draw_sel=0, busy=0, frame_done=0, err_timeout=0, overrun=0, overrun_count=0, internal mask/idx/counters=0.
- Reset mid-frame drops draw_sel on the next edge. No completion pulse is produced.
- Mode mask: START=8'h01, OVER=8'h02, PLAY=8'hFC, BLANK=8'h00.
- Active mask = mode mask AND en_mask. It is latched once on the accepted tick; changes to mode or en_mask mid-frame have no effect.
- Outputs are Moore, decoded from registered state.
- States:
  - IDLE: frame_tick → latch active mask, idx=0 → SCAN.
  - SCAN (1 cycle): combinational priority encoder finds the lowest set mask bit at index >= idx. If found, cur=that index → DRAW. If none → FRAME_END.
  - DRAW: draw_sel = 1<<cur; the watchdog counter increments each cycle.
    - plot_done high → GAP.
    - Counter reaches TIMEOUT_CYCLES-1 without plot_done → set err_timeout, → GAP (item abandoned).
    - plot_done is ignored outside DRAW.
  - GAP: draw_sel=0 for exactly GAP_CYCLES cycles, which lets the plotters reset their counters. Then idx=cur+1 → SCAN. For cur=7, SCAN finds none.
  - FRAME_END (1 cycle): frame_done=1, busy=0 → IDLE.
    - A frame_tick in this cycle is accepted: mask is latched and the next state is SCAN directly, not IDLE.
- Latency:
  - Tick sampled at edge N puts the FSM in SCAN after N.
  - First draw_sel asserts after edge N+1.
  - plot_done sampled at edge M puts the FSM in GAP after M, so draw_sel is low from M.
- Empty mask (BLANK, or all enables off): IDLE → SCAN → FRAME_END, giving a frame_done pulse 2 cycles after the tick with draw_sel never asserted.
- frame_tick while busy (SCAN, DRAW, GAP):
  - The tick is dropped and overrun is set.
  - overrun_count increments and saturates at all-ones.
  - The current frame continues unaffected.
- err_clear:
  - Clears err_timeout, overrun and overrun_count.
  - If err_clear coincides with a new overrun or timeout, the set wins.
  - err_clear has no effect on the FSM.
- Invariant: draw_sel is always one-hot or zero, never two bits set.
- Watchdog counter: width $clog2(TIMEOUT_CYCLES)+1, reset on every entry to DRAW.

Test Plan:
- Reset, mode=PLAY, en_mask=FF, tick; plot_done 10 cycles after each draw → draw_sel sequence 04,08,10,20,40,80, each item followed by 2 zero cycles, then one frame_done; busy is low afterward.
- mode=START, en_mask=FF, tick → only draw_sel=01, then frame_done. With mode=OVER → only 02.
- mode=PLAY, en_mask=8'hA4 → items 2,5,7 only (04,20,80). Change mode to START mid-frame → sequence unchanged.
- mode=BLANK, tick at edge N → frame_done high in cycle N+2, draw_sel stays 0.
- Hold plot_done low with TIMEOUT_CYCLES=16 → after 16 DRAW cycles err_timeout=1, scheduler advances to the next item. err_clear → flag 0.
- During a frame, issue 3 ticks → overrun=1, overrun_count=3. Issue a tick in the FRAME_END cycle → next frame starts without an IDLE cycle and the count is unchanged. Assert reset during DRAW → draw_sel=0 next cycle, no frame_done.
